// File: rtl/mult_stage_pkg.sv
// Shared widths and saturation limits for the dot-product datapath.
// Imported by the multiply stage and the adder tree.
package mult_stage_pkg;

  localparam int N_LANES = 28;
  localparam int W_WIDTH = 19;
  localparam int P_WIDTH = 10;
  localparam int O_WIDTH = 26;
  localparam int F_WIDTH = W_WIDTH + P_WIDTH + 1;

  localparam logic [O_WIDTH-1:0] SAT_MAX = 26'h1FFFFFF;
  localparam logic [O_WIDTH-1:0] SAT_MIN = 26'h2000000;

  localparam logic signed [F_WIDTH-1:0] F_MAX =
    F_WIDTH'(2 ** (O_WIDTH - 1) - 1);
  localparam logic signed [F_WIDTH-1:0] F_MIN = ~F_MAX;

  function automatic logic [O_WIDTH-1:0] sat_prod(
    input logic signed [F_WIDTH-1:0] f
  );
    logic [O_WIDTH-1:0] r;
    unique case (1'b1)
      (f > F_MAX): r = SAT_MAX;
      (f < F_MIN): r = SAT_MIN;
      default:     r = f[O_WIDTH-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_stage_if.sv
// Packed weight/pixel/product buses of the multiply stage.
// Lane 0 sits in the MSBs of every bus.
interface mult_stage_if;
  import mult_stage_pkg::*;

  logic [N_LANES*W_WIDTH-1:0] WeightX;
  logic [N_LANES*P_WIDTH-1:0] PixelX;
  logic [N_LANES*O_WIDTH-1:0] Output_syn;

  modport master (
    output WeightX,
    output PixelX,
    input  Output_syn
  );

  modport slave (
    input  WeightX,
    input  PixelX,
    output Output_syn
  );

endinterface

// File: rtl/mult_stage_lane.sv
// One signed-weight x unsigned-pixel lane.
// Saturates to the product width and registers the result.
module mult_lane
  import mult_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_WIDTH-1:0] w,
  input  logic [P_WIDTH-1:0] p,
  output logic [O_WIDTH-1:0] prod
);

  logic signed [F_WIDTH-1:0] full;

  // zero-extended pixel keeps the multiply fully signed
  assign full = $signed(w) * $signed({1'b0, p});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else begin
      prod <= sat_prod(full);
    end
  end

endmodule

// File: rtl/mult_stage.sv
// Parallel multiply stage: 28 independent saturating lanes.
// Unpacks MSB-first buses, repacks registered products.
module mult_stage
  import mult_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic [N_LANES*W_WIDTH-1:0] WeightX,
  input  logic [N_LANES*P_WIDTH-1:0] PixelX,
  output logic [N_LANES*O_WIDTH-1:0] Output_syn
);

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    mult_lane u_lane (
      .clk   (clk),
      .rst_n (GlobalReset),
      .w     (WeightX[(N_LANES-i)*W_WIDTH-1 -: W_WIDTH]),
      .p     (PixelX[(N_LANES-i)*P_WIDTH-1 -: P_WIDTH]),
      .prod  (Output_syn[(N_LANES-i)*O_WIDTH-1 -: O_WIDTH])
    );
  end

endmodule

// File: tb/tb_mult_stage.sv
// Scoreboard bench for mult_stage.
// Stimulus pushes expected products; a monitor pops after each edge.
module tb_mult_stage;
  import mult_stage_pkg::*;

  typedef logic [N_LANES*W_WIDTH-1:0] wbus_t;
  typedef logic [N_LANES*P_WIDTH-1:0] pbus_t;
  typedef logic [N_LANES*O_WIDTH-1:0] obus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  obus_t sb[$];

  mult_stage_if bus ();

  mult_stage dut (
    .clk         (clk),
    .GlobalReset (rst_n),
    .WeightX     (bus.WeightX),
    .PixelX      (bus.PixelX),
    .Output_syn  (bus.Output_syn)
  );

  always #5 clk = ~clk;

  function automatic wbus_t set_w(
    input wbus_t v, input int i, input logic [W_WIDTH-1:0] x
  );
    v[(N_LANES-1-i)*W_WIDTH +: W_WIDTH] = x;
    return v;
  endfunction

  function automatic pbus_t set_p(
    input pbus_t v, input int i, input logic [P_WIDTH-1:0] x
  );
    v[(N_LANES-1-i)*P_WIDTH +: P_WIDTH] = x;
    return v;
  endfunction

  function automatic obus_t set_o(
    input obus_t v, input int i, input logic [O_WIDTH-1:0] x
  );
    v[(N_LANES-1-i)*O_WIDTH +: O_WIDTH] = x;
    return v;
  endfunction

  function automatic logic [O_WIDTH-1:0] ref_prod(
    input logic [W_WIDTH-1:0] w, input logic [P_WIDTH-1:0] p
  );
    longint pr;
    longint hi;
    longint lo;
    hi = 33554431;
    lo = -33554432;
    pr = longint'($signed(w)) * longint'({1'b0, p});
    if (pr > hi) return 26'h1FFFFFF;
    if (pr < lo) return 26'h2000000;
    return pr[O_WIDTH-1:0];
  endfunction

  function automatic obus_t ref_bus(input wbus_t w, input pbus_t p);
    obus_t o;
    o = '0;
    for (int i = 0; i < N_LANES; i++) begin
      o = set_o(o, i, ref_prod(
        w[(N_LANES-1-i)*W_WIDTH +: W_WIDTH],
        p[(N_LANES-1-i)*P_WIDTH +: P_WIDTH]));
    end
    return o;
  endfunction

  task automatic chk(input string nm, input obus_t act, input obus_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input wbus_t w, input pbus_t p, input obus_t exp);
    @(negedge clk);
    bus.WeightX = w;
    bus.PixelX = p;
    sb.push_back(exp);
  endtask

  initial begin : monitor
    obus_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb", bus.Output_syn, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    wbus_t w;
    pbus_t p;
    obus_t e;
    logic [W_WIDTH-1:0] dw [4];
    logic [P_WIDTH-1:0] dp [4];
    logic [O_WIDTH-1:0] dq [4];
    logic [W_WIDTH-1:0] sw [3];
    logic [O_WIDTH-1:0] sq [3];

    dw = '{19'h7FFCD, 19'h7FFFD, 19'd42, 19'h7FFFD};
    dp = '{10'd0, 10'd222, 10'd254, 10'd170};
    dq = '{26'd0, 26'h3FFFD66, 26'h00029AC, 26'h3FFFE02};
    sw = '{19'h3FFFF, 19'h40000, 19'd32767};
    sq = '{26'h1FFFFFF, 26'h2000000, 26'd33520641};

    bus.WeightX = '1;
    bus.PixelX = '1;
    #1;
    chk("reset_state", bus.Output_syn, '0);

    // get a nonzero output, then reset asynchronously mid-cycle
    @(negedge clk);
    rst_n = 1'b1;
    w = set_w('0, 0, 19'd42);
    p = set_p('0, 0, 10'd254);
    drive(w, p, set_o('0, 0, 26'h00029AC));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_clear", bus.Output_syn, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", bus.Output_syn, '0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = set_w('0, 0, dw[k]);
      p = set_p('0, 0, dp[k]);
      drive(w, p, set_o('0, 0, dq[k]));
    end

    for (int i = 0; i < N_LANES; i++) begin
      w = set_w('0, i, 19'h7FFFD);
      p = set_p('0, i, 10'd222);
      drive(w, p, set_o('0, i, 26'h3FFFD66));
    end

    for (int k = 0; k < 3; k++) begin
      w = set_w('0, 0, sw[k]);
      p = set_p('0, 0, 10'd1023);
      drive(w, p, set_o('0, 0, sq[k]));
    end

    for (int i = 0; i < N_LANES; i++) begin
      w = set_w('0, i, 19'd1);
      drive(w, '1, set_o('0, i, 26'd1023));
    end

    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N_LANES; i++) begin
        w = set_w(w, i, W_WIDTH'($urandom));
        p = set_p(p, i, P_WIDTH'($urandom));
      end
      drive(w, p, ref_bus(w, p));
    end

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_clear", bus.Output_syn, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N_LANES; i++) begin
      w = set_w(w, i, W_WIDTH'(i * 1000 - 9000));
      p = set_p(p, i, P_WIDTH'(i * 37));
    end
    drive(w, p, ref_bus(w, p));

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
